tt_trng_ctrl: RTL and testbench

TT_TRNG_CTRL -- requirements
Module: tt_trng_ctrl

---
 rtl/tt_trng_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tt_trng_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_trng_ctrl.sv
// rtl/tt_trng_ctrl.sv - ring-oscillator TRNG controller: warm-up, 4-bit key collection, repetition health test
`timescale 1ns/1ps

module tt_trng_ctrl #(
    parameter int WARMUP_CYC = 32,
    parameter int REP_LIMIT  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       raw_bit,
    input  logic       key_ready,
    input  logic       fault_clr,
    output logic       ring_en,
    output logic       key_valid,
    output logic [3:0] key_data,
    output logic       busy,
    output logic       health_fail,
    output logic [7:0] key_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COLLECT,
        S_PRESENT,
        S_FAULT
    } state_t;

    localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYC - 1);
    localparam logic [3:0] REP_MAX   = 4'(REP_LIMIT);

    state_t     state;
    state_t     state_nx;
    logic [7:0] warm_cnt;
    logic [7:0] warm_cnt_nx;
    logic [1:0] bit_cnt;
    logic [1:0] bit_cnt_nx;
    logic [3:0] shift_reg;
    logic [3:0] shift_nx;
    logic [3:0] sampled_key;
    logic       last_bit;
    logic       last_bit_nx;
    logic [3:0] run_len;
    logic [3:0] run_len_nx;
    logic [3:0] run_sample;
    logic [3:0] key_data_nx;
    logic [7:0] key_count_nx;
    logic       active_nx;

    // run_len of zero marks "no bit sampled yet", so the first sample starts a run of one
    always_comb begin
        run_sample  = 4'd1;
        sampled_key = {shift_reg[2:0], raw_bit};
        if ((run_len != 4'd0) && (raw_bit == last_bit)) begin
            run_sample = run_len + 4'd1;
        end
    end

    always_comb begin
        state_nx     = state;
        warm_cnt_nx  = warm_cnt;
        bit_cnt_nx   = bit_cnt;
        shift_nx     = shift_reg;
        last_bit_nx  = last_bit;
        run_len_nx   = run_len;
        key_data_nx  = key_data;
        key_count_nx = key_count;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx    = S_WARMUP;
                    warm_cnt_nx = 8'd0;
                    bit_cnt_nx  = 2'd0;
                    shift_nx    = 4'd0;
                    last_bit_nx = 1'b0;
                    run_len_nx  = 4'd0;
                end
            end

            S_WARMUP: begin
                if (!start) begin
                    state_nx    = S_IDLE;
                    warm_cnt_nx = 8'd0;
                end else if (warm_cnt == WARM_LAST) begin
                    state_nx    = S_COLLECT;
                    warm_cnt_nx = 8'd0;
                    bit_cnt_nx  = 2'd0;
                    shift_nx    = 4'd0;
                end else begin
                    warm_cnt_nx = warm_cnt + 8'd1;
                end
            end

            S_COLLECT: begin
                if (!start) begin
                    state_nx   = S_IDLE;
                    bit_cnt_nx = 2'd0;
                    shift_nx   = 4'd0;
                end else begin
                    shift_nx    = sampled_key;
                    last_bit_nx = raw_bit;
                    run_len_nx  = run_sample;
                    bit_cnt_nx  = bit_cnt + 2'd1;
                    // a tripped health test outranks a key completing on the same bit
                    if (run_sample >= REP_MAX) begin
                        state_nx   = S_FAULT;
                        bit_cnt_nx = 2'd0;
                        shift_nx   = 4'd0;
                    end else if (bit_cnt == 2'd3) begin
                        state_nx    = S_PRESENT;
                        key_data_nx = sampled_key;
                        bit_cnt_nx  = 2'd0;
                    end
                end
            end

            S_PRESENT: begin
                if (key_ready) begin
                    key_count_nx = key_count + 8'd1;
                    shift_nx     = 4'd0;
                    state_nx     = start ? S_COLLECT : S_IDLE;
                end
            end

            S_FAULT: begin
                if (fault_clr && !start) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign active_nx = (state_nx == S_WARMUP) || (state_nx == S_COLLECT) ||
                       (state_nx == S_PRESENT);

    // outputs are decoded from the next state so they change on the same edge as the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            warm_cnt    <= 8'd0;
            bit_cnt     <= 2'd0;
            shift_reg   <= 4'd0;
            last_bit    <= 1'b0;
            run_len     <= 4'd0;
            key_data    <= 4'd0;
            key_count   <= 8'd0;
            ring_en     <= 1'b0;
            busy        <= 1'b0;
            key_valid   <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            state       <= state_nx;
            warm_cnt    <= warm_cnt_nx;
            bit_cnt     <= bit_cnt_nx;
            shift_reg   <= shift_nx;
            last_bit    <= last_bit_nx;
            run_len     <= run_len_nx;
            key_data    <= key_data_nx;
            key_count   <= key_count_nx;
            ring_en     <= active_nx;
            busy        <= active_nx;
            key_valid   <= (state_nx == S_PRESENT);
            health_fail <= (state_nx == S_FAULT);
        end
    end

endmodule

// File: tb/tb_tt_trng_ctrl.sv
// tb/tb_tt_trng_ctrl.sv - scoreboard bench for tt_trng_ctrl with a bit-history reference model
`timescale 1ns/1ps

module tb_tt_trng_ctrl;

    localparam int W  = 4;
    localparam int RL = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       raw_bit;
    logic       key_ready;
    logic       fault_clr;
    logic       ring_en;
    logic       key_valid;
    logic [3:0] key_data;
    logic       busy;
    logic       health_fail;
    logic [7:0] key_count;

    tt_trng_ctrl #(.WARMUP_CYC(W), .REP_LIMIT(RL)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .raw_bit    (raw_bit),
        .key_ready  (key_ready),
        .fault_clr  (fault_clr),
        .ring_en    (ring_en),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .busy       (busy),
        .health_fail(health_fail),
        .key_count  (key_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] key;
        logic [7:0] cnt;
    } exp_t;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   hist[$];
    int   exp_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // length of the identical-bit run that ends with b if b were appended to q
    function automatic int run_in(input bit q[$], input bit b);
        int r = 1;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i] != b) break;
            r++;
        end
        return r;
    endfunction

    function automatic bit would_fault(input logic [3:0] k);
        bit q[$];
        q = hist;
        for (int i = 3; i >= 0; i--) begin
            if (run_in(q, k[i]) >= RL) return 1'b1;
            q.push_back(k[i]);
        end
        return 1'b0;
    endfunction

    function automatic logic [3:0] gen_key(input bit safe);
        logic [3:0] k;
        bit         lb;
        lb = (hist.size() > 0) ? hist[$] : 1'b0;
        if (safe) begin
            for (int t = 0; t < 8; t++) begin
                k = 4'($urandom);
                if (!would_fault(k)) return k;
            end
            return {~lb, lb, ~lb, lb};
        end
        if ($urandom_range(0, 2) == 0) return {4{lb}};
        return 4'($urandom);
    endfunction

    task automatic collect_key(input logic [3:0] k, output bit faulted);
        faulted = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            raw_bit = k[i];
            if (run_in(hist, k[i]) >= RL) begin
                step();
                faulted = 1'b1;
                hist.delete();
                chk("fault_health_fail", health_fail, 1);
                chk("fault_ring_en", ring_en, 0);
                chk("fault_busy", busy, 0);
                chk("fault_no_key", key_valid, 0);
                return;
            end
            hist.push_back(k[i]);
            step();
            if (i > 0) chk("valid_in_collect", key_valid, 0);
        end
        chk("valid_after_4_bits", key_valid, 1);
        exp_q.push_back('{key: k, cnt: 8'(exp_count)});
    endtask

    task automatic accept_key(input int delay);
        key_ready = 1'b0;
        repeat (delay) begin
            step();
            chk("hold_valid", key_valid, 1);
        end
        key_ready = 1'b1;
        step();
        exp_count = (exp_count + 1) % 256;
        chk("count_after_accept", key_count, exp_count);
        chk("valid_drop_after_accept", key_valid, 0);
        key_ready = 1'($urandom);
    endtask

    task automatic fault_seq();
        fault_clr = 1'b1;
        start     = 1'b1;
        repeat (3) step();
        chk("fault_clr_ignored", health_fail, 1);
        chk("fault_stays_idle_ring", ring_en, 0);
        start = 1'b0;
        step();
        chk("fault_cleared", health_fail, 0);
        chk("fault_cleared_busy", busy, 0);
        fault_clr = 1'b0;
        step();
        chk("idle_after_clear", busy, 0);
    endtask

    task automatic session(input int nkeys, input bit use_fk, input logic [3:0] fk,
                           input int delay, input bit drop_last);
        bit         f;
        logic [3:0] k;
        hist.delete();
        fault_clr = 1'b0;
        start     = 1'b1;
        raw_bit   = 1'($urandom);
        step();
        chk("ring_en_warmup", ring_en, 1);
        chk("busy_warmup", busy, 1);
        repeat (W) begin
            raw_bit = 1'($urandom);
            step();
            chk("valid_in_warmup", key_valid, 0);
        end
        for (int ki = 0; ki < nkeys; ki++) begin
            k = use_fk ? fk : gen_key(1'b0);
            collect_key(k, f);
            if (f) begin
                fault_seq();
                return;
            end
            if (drop_last && (ki == nkeys - 1)) start = 1'b0;
            accept_key((delay < 0) ? int'($urandom_range(0, 4)) : delay);
        end
        if (start) begin
            start = 1'b0;
            step();
        end
        chk("end_busy", busy, 0);
        chk("end_ring_en", ring_en, 0);
        chk("end_valid", key_valid, 0);
    endtask

    task automatic collect_drop();
        hist.delete();
        start = 1'b1;
        step();
        repeat (W) step();
        raw_bit = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("drop_ring_en", ring_en, 0);
        chk("drop_busy", busy, 0);
        chk("drop_valid", key_valid, 0);
        repeat (3) step();
        chk("drop_no_key", key_valid, 0);
    endtask

    task automatic bulk(input int n);
        bit         f;
        logic [3:0] k;
        hist.delete();
        start     = 1'b1;
        key_ready = 1'b1;
        step();
        repeat (W) step();
        for (int i = 0; i < n; i++) begin
            k = gen_key(1'b1);
            collect_key(k, f);
            if (!f) accept_key(0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ring_en"}, ring_en, 0);
        chk({tag, "_key_valid"}, key_valid, 0);
        chk({tag, "_key_data"}, key_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_health_fail"}, health_fail, 0);
        chk({tag, "_key_count"}, key_count, 0);
    endtask

    // scoreboard monitor: compares every accepted key against the queued expectation
    logic       prev_v = 1'b0;
    logic       prev_a = 1'b0;
    logic [3:0] prev_d = 4'd0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            prev_a = 1'b0;
        end else begin
            if (key_valid) begin
                if (prev_v && !prev_a) chk("key_stable", key_data, prev_d);
                if (key_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_key: got %0h expected no key", key_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("key_data", key_data, mon_e.key);
                        chk("key_count_at_accept", key_count, mon_e.cnt);
                    end
                end
            end
            prev_v = key_valid;
            prev_a = key_valid && key_ready;
            prev_d = key_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit         f;
        logic [3:0] k;
        rst       = 1'b1;
        start     = 1'b0;
        raw_bit   = 1'b0;
        key_ready = 1'b0;
        fault_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) step();
        chk("idle_wait_busy", busy, 0);
        chk("idle_wait_ring", ring_en, 0);

        session(1, 1'b1, 4'hB, 0, 1'b0);
        session(1, 1'b1, 4'hB, 10, 1'b0);
        session(2, 1'b1, 4'h0, 0, 1'b0);
        collect_drop();
        session(2, 1'b0, 4'h0, -1, 1'b1);
        repeat (25) session(int'($urandom_range(1, 4)), 1'b0, 4'h0, -1, 1'($urandom));

        rst = 1'b1;
        step();
        rst       = 1'b0;
        exp_count = 0;
        exp_q.delete();
        bulk(255);
        key_ready = 1'b0;
        k = gen_key(1'b1);
        collect_key(k, f);
        key_ready = 1'b0;
        repeat (2) step();
        chk("pre_reset_count", key_count, 255);
        chk("pre_reset_valid", key_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        step();
        rst       = 1'b0;
        start     = 1'b0;
        exp_count = 0;
        step();
        chk("post_reset_idle", busy, 0);

        bulk(256);
        start = 1'b0;
        step();
        chk("count_wrap", key_count, 0);
        chk("wrap_idle", busy, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
